button_reader: RTL and testbench

// - Input-side counterpart of the LED output peripheral: samples N_BTN asynchronous push-button pins and

---
 rtl/cortex_io_pkg.sv | 16 +
 rtl/btn_debounce.sv | 96 +++++++++
 rtl/button_reader.sv | 73 +++++++
 tb/tb_button_reader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cortex_io_pkg.sv
// Shared definitions for the Cortex-M0 I/O peripherals: status word field
// positions and the debounce state encoding.
package cortex_io_pkg;

  localparam int BTN_LVL_LSB = 0;
  localparam int BTN_PRS_LSB = 8;
  localparam int BTN_REL_LSB = 16;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_RISE = 2'd1,
    S_HI   = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer followed by a debounce FSM with a
// saturating stability counter; emits the debounced level and 1-cycle edge pulses.
module btn_debounce
  import cortex_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);

  logic          r_meta;
  logic          r_sync;
  deb_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic [CW-1:0] w_inc;
  logic          w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  // w_inc counts the sample being taken this cycle, so a change is accepted on
  // the DEBOUNCE_CYCLES-th consecutive stable sample (2 + DEBOUNCE_CYCLES edges
  // from the pin).
  assign w_inc = (r_cnt == C_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_hit = (w_inc == C_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_LO;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_LO, S_RISE: begin
          if (!r_sync) begin
            r_state <= S_LO;
            r_cnt   <= '0;
          end else if (w_hit) begin
            r_state <= S_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_state <= S_RISE;
            r_cnt   <= w_inc;
          end
        end
        S_HI, S_FALL: begin
          if (r_sync) begin
            r_state <= S_HI;
            r_cnt   <= '0;
          end else if (w_hit) begin
            r_state   <= S_LO;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_state <= S_FALL;
            r_cnt   <= w_inc;
          end
        end
        default: begin
          r_state <= S_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader with sticky press/release flags and a read-capture
// status register. Optional level interrupt when BTN_IRQ_EN is defined.
module button_reader
  import cortex_io_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [N_BTN-1:0] i_btn,
  output logic [31:0]      o_reg,
  output logic             o_irq
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] r_prs;
  logic [N_BTN-1:0] r_rel;
  logic [31:0]      r_reg;
  logic [31:0]      w_word;

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .i_pin    (i_btn[g]),
      .o_level  (w_level[g]),
      .o_press  (w_press[g]),
      .o_release(w_release[g])
    );
  end

  always_comb begin
    w_word = '0;
    w_word[BTN_LVL_LSB +: N_BTN] = w_level;
    w_word[BTN_PRS_LSB +: N_BTN] = r_prs;
    w_word[BTN_REL_LSB +: N_BTN] = r_rel;
  end

  // A read clears the flags, but an event arriving on the same edge re-sets them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg <= '0;
      r_prs <= '0;
      r_rel <= '0;
    end else begin
      if (rd_en) r_reg <= w_word;
      r_prs <= (rd_en ? '0 : r_prs) | w_press;
      r_rel <= (rd_en ? '0 : r_rel) | w_release;
    end
  end

  assign o_reg = r_reg;

`ifdef BTN_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= |r_prs;
  end

  assign o_irq = r_irq;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader with N_BTN=4, DEBOUNCE_CYCLES=4; read captures are
// checked through an expected-value queue popped after each read edge.
module tb_button_reader;

  localparam int N = 4;
  localparam int D = 4;
`ifdef BTN_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0;
  logic [N-1:0]  i_btn = '1;
  logic [31:0]   o_reg;
  logic          o_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] q_exp[$];

  button_reader #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .rd_en(rd_en),
    .i_btn(i_btn),
    .o_reg(o_reg),
    .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  always @(posedge clk) begin
    if (rd_en && rst) begin
      logic [31:0] exp_v;
      #1;
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL read_capture: got %h with no expected value queued", o_reg);
      end else begin
        exp_v = q_exp.pop_front();
        if (o_reg !== exp_v) begin
          errors++;
          $display("FAIL read_capture: o_reg=%h expected %h at %0t", o_reg, exp_v, $time);
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    rd_en = 1'b0;
    i_btn = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] exp_v);
    @(negedge clk);
    q_exp.push_back(exp_v);
    rd_en = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (o_reg !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg: o_reg=%h expected 0", o_reg);
      end
      checks++;
      if (o_irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_irq: o_irq=%b expected 0", o_irq);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    rd(32'h0000_0000);
    rd(32'h0000_000F);
    rd(32'h0000_0F0F);
    rd(32'h0000_000F);
  endtask

  task automatic test_back_to_back;
    drive(4'h0);
    idle(4);
    rd(32'h0000_000F);
    rd(32'h0000_0000);
    rd(32'h000F_0000);
    rd(32'h0000_0000);
  endtask

  task automatic test_glitch;
    drive(4'b0100);
    idle(2);
    drive(4'b0000);
    idle(10);
    rd(32'h0000_0000);
  endtask

  task automatic test_sticky;
    drive(4'b0010);
    idle(10);
    drive(4'b0000);
    idle(10);
    rd(32'h0002_0200);
    rd(32'h0000_0000);
  endtask

  task automatic test_clean_press;
    drive(4'b0001);
    idle(10);
    rd(32'h0000_0101);
    rd(32'h0000_0001);
  endtask

  task automatic test_irq;
    logic exp_irq;
    drive(4'b1001);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_irq = IRQ_ON && (k >= 8);
      checks++;
      if (o_irq !== exp_irq) begin
        errors++;
        $display("FAIL irq_rise k=%0d: o_irq=%b expected %b", k, o_irq, exp_irq);
      end
    end
    rd(32'h0000_0809);
    @(posedge clk);
    #2;
    checks++;
    if (o_irq !== IRQ_ON) begin
      errors++;
      $display("FAIL irq_read_edge: o_irq=%b expected %b", o_irq, IRQ_ON);
    end
    @(negedge clk);
    rd_en = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: o_irq=%b expected 0", o_irq);
    end
    idle(3);
    checks++;
    if (o_reg !== 32'h0000_0809) begin
      errors++;
      $display("FAIL reg_hold: o_reg=%h expected 00000809", o_reg);
    end
  endtask

  task automatic test_reset_mid;
    drive(4'b1101);
    idle(3);
    #2;
    rst = 1'b0;
    i_btn = 4'b0000;
    #1;
    checks++;
    if (o_reg !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: o_reg=%h expected 0", o_reg);
    end
    checks++;
    if (o_irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_irq: o_irq=%b expected 0", o_irq);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(10);
    rd(32'h0000_0000);
    idle(2);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_sticky();
    test_clean_press();
    test_irq();
    test_reset_mid();
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected reads not observed", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
